// File: rtl/timebase_gen_if.sv
// rtl/timebase_gen_if.sv - control and strobe bundle for the multi-channel timebase generator
//
// Signals (direction given for the slave side, i.e. the generator):
//   en        in   global enable; low freezes prescaler and all channel counters
//   load      in   per-channel one-cycle load strobe
//   mode      in   per-channel mode, sampled on load (0 periodic, 1 one-shot)
//   period    in   packed per-channel periods, slice c is period[c*CW +: CW]
//   base_tick out  registered one-cycle pulse at the base rate
//   tick      out  registered one-cycle pulse per channel expiry
//   active    out  channel is counting
interface timebase_gen_if #(
  parameter int N_CH = 4,
  parameter int CW   = 16
);
  logic                 en;
  logic [N_CH-1:0]      load;
  logic [N_CH-1:0]      mode;
  logic [N_CH*CW-1:0]   period;
  logic                 base_tick;
  logic [N_CH-1:0]      tick;
  logic [N_CH-1:0]      active;

  modport master (
    output en, load, mode, period,
    input  base_tick, tick, active
  );

  modport slave (
    input  en, load, mode, period,
    output base_tick, tick, active
  );
endinterface

// File: rtl/timebase_gen.sv
// rtl/timebase_gen.sv - shared prescaler plus N_CH independent periodic/one-shot channel dividers
//
// Ports:
//   clk  in   sole clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of timebase_gen_if (en/load/mode/period in,
//        base_tick/tick/active out); all outputs are registered
module timebase_gen #(
  parameter int CLK_HZ  = 25_000_000,
  parameter int BASE_HZ = 1_000_000,
  parameter int N_CH    = 4,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  timebase_gen_if.slave bus
);

  localparam int PRE = CLK_HZ / BASE_HZ;
  localparam int PW  = (PRE > 1) ? $clog2(PRE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);

  if (BASE_HZ <= 0 || (CLK_HZ % BASE_HZ) != 0 || PRE < 1) begin : g_bad_ratio
    $error("timebase_gen: CLK_HZ must be a positive integer multiple of BASE_HZ");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("timebase_gen: N_CH must be in 1..16");
  end
  if (CW < 1) begin : g_bad_cw
    $error("timebase_gen: CW must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Prescaler. With PRE == 1 the counter is stuck at 0 == PRE_LAST, so the
  // strobe collapses to en.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_cnt;
  logic          bstb;
  logic          base_tick_r;

  assign bstb = bus.en && (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt     <= '0;
      base_tick_r <= 1'b0;
    end else begin
      base_tick_r <= bstb;
      if (bus.en) begin
        pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channels. Load outranks expiry: a load coinciding with bstb discards the
  // old count without ticking. bstb already carries en, so a frozen block
  // never decrements, while load still takes effect.
  // ---------------------------------------------------------------------------
  logic [CW-1:0]   per_r [N_CH];
  logic [CW-1:0]   cnt   [N_CH];
  logic [N_CH-1:0] os_r;
  logic [N_CH-1:0] active_r;
  logic [N_CH-1:0] tick_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        per_r[c] <= '0;
        cnt[c]   <= '0;
      end
      os_r     <= '0;
      active_r <= '0;
      tick_r   <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        tick_r[c] <= 1'b0;
        if (bus.load[c]) begin
          per_r[c]    <= bus.period[c*CW +: CW];
          cnt[c]      <= bus.period[c*CW +: CW];
          os_r[c]     <= bus.mode[c];
          // Period 0 is the stop command.
          active_r[c] <= (bus.period[c*CW +: CW] != '0);
        end else if (bstb && active_r[c]) begin
          if (cnt[c] == CW'(1)) begin
            tick_r[c] <= 1'b1;
            if (os_r[c]) begin
              // One-shot: active falls on the same edge tick rises.
              active_r[c] <= 1'b0;
              cnt[c]      <= '0;
            end else begin
              cnt[c] <= per_r[c];
            end
          end else begin
            cnt[c] <= cnt[c] - CW'(1);
          end
        end
      end
    end
  end

  assign bus.base_tick = base_tick_r;
  assign bus.tick      = tick_r;
  assign bus.active    = active_r;

endmodule

// File: tb/tb_timebase_gen.sv
// tb/tb_timebase_gen.sv - directed self-checking bench for timebase_gen (PRE=25, N_CH=4, CW=16)
module tb_timebase_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timebase_gen_if #(.N_CH(4), .CW(16)) bus ();

  timebase_gen #(
    .CLK_HZ (25_000_000),
    .BASE_HZ(1_000_000),
    .N_CH   (4),
    .CW     (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // cyc is the cycle whose inputs are being driven and whose outputs are
  // sampled at the current negedge (cycle 0 = first edge with rst low, en high).
  int cyc;
  int nvec;
  int nerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic bt, input logic [3:0] tk, input logic [3:0] ac);
    chk({tag, ".base_tick"}, {31'd0, bus.base_tick}, {31'd0, bt});
    chk({tag, ".tick"},      {28'd0, bus.tick},      {28'd0, tk});
    chk({tag, ".active"},    {28'd0, bus.active},    {28'd0, ac});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic load_ch(input int c, input logic [15:0] p, input logic m);
    bus.load[c]          = 1'b1;
    bus.mode[c]          = m;
    bus.period[c*16 +: 16] = p;
  endtask

  task automatic reset_release(input string tag);
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.load   = '0;
    bus.mode   = '0;
    bus.period = '0;
    step();
    step();
    chk_all({tag, ".rst"}, 1'b0, 4'h0, 4'h0);
    rst    = 1'b0;
    bus.en = 1'b1;
    cyc    = 0;
  endtask

  function automatic logic bt_sched(input int k);
    return (k > 0) && (k % 25 == 0);
  endfunction

  initial begin
    nvec = 0;
    nerr = 0;
    cyc  = 0;
    rst  = 1'b1;
    bus.en = 1'b0;
    bus.load = '0;
    bus.mode = '0;
    bus.period = '0;
    @(negedge clk);

    // Reset / prescale
    reset_release("pre");
    while (cyc <= 80) begin
      chk_all("pre", bt_sched(cyc), 4'h0, 4'h0);
      step();
    end

    // Periodic, period 3 on channel 0
    reset_release("per");
    while (cyc <= 230) begin
      chk_all("per", bt_sched(cyc),
              {3'b000, (cyc == 75 || cyc == 150 || cyc == 225)},
              {3'b000, (cyc >= 1)});
      bus.load = '0;
      if (cyc == 0) load_ch(0, 16'd3, 1'b0);
      step();
    end

    // One-shot, period 2 on channel 1
    reset_release("os");
    while (cyc <= 500) begin
      chk_all("os", bt_sched(cyc),
              {2'b00, (cyc == 50), 1'b0},
              {2'b00, (cyc >= 1 && cyc < 50), 1'b0});
      bus.load = '0;
      if (cyc == 0) load_ch(1, 16'd2, 1'b1);
      step();
    end

    // Load collision and stop on channel 2
    reset_release("col");
    while (cyc <= 260) begin
      chk_all("col", bt_sched(cyc),
              {1'b0, (cyc == 25 || cyc == 150), 2'b00},
              {1'b0, (cyc >= 1 && cyc <= 160), 2'b00});
      bus.load = '0;
      if (cyc == 0)   load_ch(2, 16'd1, 1'b0);
      if (cyc == 49)  load_ch(2, 16'd4, 1'b0);
      if (cyc == 160) load_ch(2, 16'd0, 1'b0);
      step();
    end

    // Enable freeze for cycles 60..99
    reset_release("frz");
    while (cyc <= 200) begin
      chk_all("frz",
              (cyc == 25 || cyc == 50 || (cyc >= 115 && (cyc - 115) % 25 == 0)),
              {3'b000, (cyc == 115 || cyc == 190)},
              {3'b000, (cyc >= 1)});
      bus.load = '0;
      if (cyc == 0) load_ch(0, 16'd3, 1'b0);
      bus.en = !(cyc >= 60 && cyc < 100);
      step();
    end
    bus.en = 1'b1;

    // Reset mid-operation
    reset_release("mid");
    while (cyc <= 60) begin
      bus.load = '0;
      if (cyc == 0) begin
        load_ch(0, 16'd1, 1'b0);
        load_ch(1, 16'd2, 1'b0);
        load_ch(2, 16'd3, 1'b0);
        load_ch(3, 16'd4, 1'b0);
      end
      if (cyc == 50) chk("mid.tick50", {28'd0, bus.tick}, 32'h3);
      if (cyc == 60) begin
        chk("mid.active60", {28'd0, bus.active}, 32'hF);
        rst = 1'b1;
      end
      step();
    end
    chk_all("mid.rst", 1'b0, 4'h0, 4'h0);
    rst = 1'b0;
    cyc = 0;
    while (cyc <= 100) begin
      chk_all("mid.post", bt_sched(cyc), 4'h0, 4'h0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
